tone_gen: RTL
=============

Name: tone_gen

Overview:
- Downstream stage of the BGM sequencer: consumes the 7-bit `scale` code (0 = rest, else half-period in time units) and drives a 1-bit square wave to the speaker/PMOD pin.
- Glitch-free: a note change takes effect only at a half-period boundary, except when starting from silence.
- 100 MHz system clock.

Parameters:
- UNIT_CYCLES, 2078, clocks per scale time unit. Half-period = scale*UNIT_CYCLES clocks; scale 92 gives ~261.5 Hz.
- SCALE_W, 7, width of the scale code.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  play enable; low = synchronous return to idle.
- scale  in  SCALE_W  note code from the sequencer; 0 = rest. Any value may change on any cycle.
- audio  out  1  square-wave output to the speaker.
- tone_active  out  1  high while a nonzero note is being generated (cur != 0).
- period_tick  out  1  one-cycle pulse coincident with every 0->1 transition of the tone phase.

Behaviour:
- Reset (async): scale_q=0, cur=0, phase=0, prescaler=0, hc=0. Outputs: audio=0, tone_active=0, period_tick=0.
- scale is registered every cycle into scale_q; all decisions use scale_q.
- Idle (cur==0):
  - audio=0, prescaler and hc held at 0.
  - When scale_q!=0 and en=1, at the next edge: cur<=scale_q, phase<=1, period_tick=1, prescaler=0, hc=0.
  - Latency: scale change on input to audio high = 2 clocks.
- Run (cur!=0):
  - Prescaler counts 0..UNIT_CYCLES-1 and wraps; unit_tick is asserted on the count UNIT_CYCLES-1.
  - hc increments on unit_tick.
  - When unit_tick and hc==cur-1: hc<=0, phase toggles, cur<=scale_q (pending note applied at the boundary).
  - If the loaded scale_q==0: phase<=0, return to Idle.
  - period_tick asserts on a toggle 0->1 only.
  - Each half-period lasts exactly cur*UNIT_CYCLES clocks.
- Note change mid-half-period: the current half-period completes with the old cur; the new value governs the next half. Multiple changes within one half: only the value present at the boundary is used.
- Same note held: continuous, no restart, no phase reset.
- en low: next edge forces the reset values (synchronous clear). en high again restarts from Idle.
- Reset asserted mid-note: immediate silence, no partial pulse afterwards.
- Arithmetic:
  - prescaler width = $clog2(UNIT_CYCLES).
  - hc is SCALE_W bits, unsigned. cur>=1 in Run, so cur-1 never underflows.
  - scale=127 is legal (longest period).
- tone_active = (cur!=0). audio = phase (see optional feature).

Optional Feature:
- Macro TONE_GEN_VOLUME_EN.
- Defined:
  - Adds input port vol[2:0].
  - A free-running 3-bit pwm_cnt (reset 0, counts every clk) gates the output: audio = phase & (pwm_cnt < vol).
  - vol=0 mutes. vol=7 gives 7/8 duty within the high phase.
  - period_tick and tone_active are unaffected.
- Undefined: no vol port, audio = phase.

Decomposition:
- Shared package audio_pkg:
  - SCALE_W=7.
  - SCALE_REST=0.
  - UNIT_CYCLES default 2078.
  - Note-code-to-scale constants, shared with the sequencer.
- One sub-module: tone_prescaler (UNIT_CYCLES counter with synchronous clear; outputs unit_tick).
- Remaining logic (note control) stays in tone_gen.

Test Plan (UNIT_CYCLES=4 override):
- Reset release with scale=0, en=1 -> audio=0, tone_active=0, no period_tick for 100 clocks.
- scale 0->3 at cycle N:
  - audio=1 and period_tick at N+2.
  - audio low at N+14, high at N+26 (period 24 clocks), period_tick every 24 clocks.
- Hold scale=3, then change to 5 six clocks into a high half:
  - that half still ends at 12 clocks.
  - the next half lasts 20 clocks.
- scale 3->0 mid-half -> audio stays high until the boundary, then 0. tone_active drops on the same edge; no further period_tick.
- Async rst mid high-phase -> audio=0 and tone_active=0 immediately, without a clock edge. After release with scale=3, restart latency is 2 clocks.
- TONE_GEN_VOLUME_EN, vol=2, scale=3 -> during each high half, audio is high in 2 of every 8 clocks (pwm_cnt 0,1). vol=0 -> audio constantly 0 while period_tick is still pulsing every 24 clocks.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions for the BGM sequencer and tone generator:
// scale-code width, rest code, default time unit and note-to-scale table.
package audio_pkg;

    localparam int unsigned SCALE_W         = 7;
    localparam int unsigned VOL_W           = 3;
    localparam int unsigned UNIT_CYCLES_DEF = 2078;

    localparam logic [SCALE_W-1:0] SCALE_REST = SCALE_W'(0);

    // Half-periods in time units of UNIT_CYCLES_DEF clocks at 100 MHz
    localparam logic [SCALE_W-1:0] SCALE_C4 = SCALE_W'(92);
    localparam logic [SCALE_W-1:0] SCALE_D4 = SCALE_W'(82);
    localparam logic [SCALE_W-1:0] SCALE_E4 = SCALE_W'(73);
    localparam logic [SCALE_W-1:0] SCALE_F4 = SCALE_W'(69);
    localparam logic [SCALE_W-1:0] SCALE_G4 = SCALE_W'(61);
    localparam logic [SCALE_W-1:0] SCALE_A4 = SCALE_W'(55);
    localparam logic [SCALE_W-1:0] SCALE_B4 = SCALE_W'(49);
    localparam logic [SCALE_W-1:0] SCALE_C5 = SCALE_W'(46);

    typedef enum logic [3:0] {
        NOTE_REST = 4'd0,
        NOTE_C4   = 4'd1,
        NOTE_D4   = 4'd2,
        NOTE_E4   = 4'd3,
        NOTE_F4   = 4'd4,
        NOTE_G4   = 4'd5,
        NOTE_A4   = 4'd6,
        NOTE_B4   = 4'd7,
        NOTE_C5   = 4'd8
    } note_e;

    function automatic logic [SCALE_W-1:0] note_to_scale(input note_e note);
        logic [SCALE_W-1:0] s;
        s = SCALE_REST;
        case (note)
            NOTE_C4: s = SCALE_C4;
            NOTE_D4: s = SCALE_D4;
            NOTE_E4: s = SCALE_E4;
            NOTE_F4: s = SCALE_F4;
            NOTE_G4: s = SCALE_G4;
            NOTE_A4: s = SCALE_A4;
            NOTE_B4: s = SCALE_B4;
            NOTE_C5: s = SCALE_C5;
            default: s = SCALE_REST;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tone_gen_prescaler.sv
// Time-unit prescaler: counts 0..UNIT_CYCLES-1 with synchronous clear and
// flags the last count of each unit with a registered unit_tick.
module tone_prescaler
    import audio_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = UNIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic unit_tick_o
);

    localparam int unsigned CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(UNIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr_i || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Registered decode of the count that will be held next cycle
        tick_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign unit_tick_o = tick_q;

endmodule

// File: rtl/tone_gen.sv
// Glitch-free square-wave tone generator driven by the sequencer's scale code.
// Optional TONE_GEN_VOLUME_EN adds a 3-bit PWM volume input.
module tone_gen
    import audio_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = UNIT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [SCALE_W-1:0] scale,
`ifdef TONE_GEN_VOLUME_EN
    input  logic [VOL_W-1:0]   vol,
`endif
    output logic               audio,
    output logic               tone_active,
    output logic               period_tick
);

    logic [SCALE_W-1:0] scale_q, scale_d;
    logic [SCALE_W-1:0] cur_q, cur_d;
    logic [SCALE_W-1:0] hc_q, hc_d;
    logic               phase_q, phase_d;
    logic               audio_q, audio_d;
    logic               active_q, active_d;
    logic               ptick_q, ptick_d;
    logic               unit_tick;
    logic               pre_clr_c;

    // Prescaler only runs while a note is playing
    assign pre_clr_c = !en || (cur_q == SCALE_REST);

    tone_prescaler #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (pre_clr_c),
        .unit_tick_o(unit_tick)
    );

`ifdef TONE_GEN_VOLUME_EN
    logic [VOL_W-1:0] pwm_q, pwm_d;

    assign pwm_d = pwm_q + VOL_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end
`endif

    // Note control: start from silence immediately, otherwise switch only at half-period ends
    always_comb begin
        scale_d = en ? scale : SCALE_REST;
        cur_d   = cur_q;
        hc_d    = hc_q;
        phase_d = phase_q;
        ptick_d = 1'b0;

        if (!en) begin
            cur_d   = SCALE_REST;
            hc_d    = '0;
            phase_d = 1'b0;
        end else if (cur_q == SCALE_REST) begin
            hc_d    = '0;
            phase_d = 1'b0;
            if (scale_q != SCALE_REST) begin
                cur_d   = scale_q;
                phase_d = 1'b1;
                ptick_d = 1'b1;
            end
        end else if (unit_tick) begin
            if (hc_q == (cur_q - SCALE_W'(1))) begin
                hc_d  = '0;
                cur_d = scale_q;
                if (scale_q == SCALE_REST) begin
                    phase_d = 1'b0;
                end else begin
                    phase_d = !phase_q;
                    ptick_d = !phase_q;
                end
            end else begin
                hc_d = hc_q + SCALE_W'(1);
            end
        end

        active_d = (cur_d != SCALE_REST);
`ifdef TONE_GEN_VOLUME_EN
        audio_d  = phase_d && (pwm_d < vol);
`else
        audio_d  = phase_d;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scale_q  <= SCALE_REST;
            cur_q    <= SCALE_REST;
            hc_q     <= '0;
            phase_q  <= 1'b0;
            audio_q  <= 1'b0;
            active_q <= 1'b0;
            ptick_q  <= 1'b0;
        end else begin
            scale_q  <= scale_d;
            cur_q    <= cur_d;
            hc_q     <= hc_d;
            phase_q  <= phase_d;
            audio_q  <= audio_d;
            active_q <= active_d;
            ptick_q  <= ptick_d;
        end
    end

    assign audio       = audio_q;
    assign tone_active = active_q;
    assign period_tick = ptick_q;

endmodule
